// File: rtl/jtdsp16_pkg.sv
// Shared types and constants for the DSP16 serial I/O blocks.
// Used by jtdsp16_sirx (the build option JTDSP16_SIRX_BYTE_EN enables 8-bit words).
package jtdsp16_pkg;

  typedef enum logic {
    SIRX_IDLE  = 1'b0,
    SIRX_SHIFT = 1'b1
  } sirx_state_t;

  localparam logic [1:0] SIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] SIO_ADDR_STAT = 2'd1;

  localparam int WORD_LEN_16 = 16;
  localparam int WORD_LEN_8  = 8;

  // Bit-counter value at which the final bit of a word is captured
  function automatic logic [3:0] last_bit(input logic byte_sel);
    return byte_sel ? 4'(WORD_LEN_8 - 1) : 4'(WORD_LEN_16 - 1);
  endfunction

endpackage

// File: rtl/jtdsp16_sync.sv
// Multi-flop synchroniser for the serial input pins plus rising-edge detect
// on the serial clock. ild and di share the same depth so they stay aligned with ick.
module jtdsp16_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ick,
  input  logic ild,
  input  logic di,
  output logic ild_s,
  output logic di_s,
  output logic ick_rise
);

  logic [STAGES-1:0] ick_ff, ild_ff, di_ff;
  logic              ick_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      ick_ff   <= '0;
      ild_ff   <= '0;
      di_ff    <= '0;
      ick_prev <= 1'b0;
    end else begin
      ick_ff   <= {ick_ff[STAGES-2:0], ick};
      ild_ff   <= {ild_ff[STAGES-2:0], ild};
      di_ff    <= {di_ff[STAGES-2:0], di};
      ick_prev <= ick_ff[STAGES-1];
    end
  end

  // Both chain and history reset low, so no edge can appear right after reset
  assign ick_rise = ick_ff[STAGES-1] & ~ick_prev;
  assign ild_s    = ild_ff[STAGES-1];
  assign di_s     = di_ff[STAGES-1];

endmodule

// File: rtl/jtdsp16_sirx.sv
// DSP16 serial input receiver: frames bits from ick/ild/di into ibuf with ibf/ovr flags.
// Define JTDSP16_SIRX_BYTE_EN to let byte_mode select 8-bit words.
module jtdsp16_sirx
  import jtdsp16_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ick,
  input  logic        ild,
  input  logic        di,
  input  logic        byte_mode,
  input  logic        sio_rd,
  input  logic [1:0]  cpu_addr,
  output logic [15:0] sio_dout,
  output logic        ibf,
  output logic        ovr,
  input  logic        siord_full,
  output logic        ext_irq
);

  logic        ild_s, di_s, ick_rise;
  sirx_state_t state_q, state_d;
  logic [3:0]  cnt_q;
  logic [15:0] sreg_q, ibuf_q;
  logic        done_q, ibf_q, ovr_q, irq_q;
  logic        cnt_clr, shift_en, word_done;
  logic        byte_sel, rd_data, rd_stat;

  jtdsp16_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .ick      (ick),
    .ild      (ild),
    .di       (di),
    .ild_s    (ild_s),
    .di_s     (di_s),
    .ick_rise (ick_rise)
  );

`ifdef JTDSP16_SIRX_BYTE_EN
  assign byte_sel = byte_mode;
`else
  logic unused_byte_mode;
  assign unused_byte_mode = byte_mode;
  assign byte_sel         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    case (state_q)
      SIRX_IDLE: begin
        if (ick_rise && ild_s) begin
          state_d = SIRX_SHIFT;
          cnt_clr = 1'b1;
        end
      end
      SIRX_SHIFT: begin
        if (ick_rise) begin
          // A frame strobe mid-word throws the partial word away
          if (ild_s) begin
            cnt_clr = 1'b1;
          end else begin
            shift_en = 1'b1;
            if (cnt_q == last_bit(byte_sel)) begin
              word_done = 1'b1;
              state_d   = SIRX_IDLE;
            end
          end
        end
      end
      default: state_d = SIRX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SIRX_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= word_done;
      if (cnt_clr) begin
        cnt_q  <= '0;
        sreg_q <= '0;
      end else if (shift_en) begin
        cnt_q  <= cnt_q + 4'd1;
        sreg_q <= {sreg_q[14:0], di_s};
      end
    end
  end

  assign rd_data = sio_rd && (cpu_addr == SIO_ADDR_DATA);
  assign rd_stat = sio_rd && (cpu_addr == SIO_ADDR_STAT);

  // A completing word beats a same-cycle data read: ibf stays set, no overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      ibuf_q <= '0;
      ibf_q  <= 1'b0;
      ovr_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      irq_q <= ibf_q & siord_full;
      if (done_q) begin
        ibuf_q <= byte_sel ? {8'd0, sreg_q[7:0]} : sreg_q;
        ibf_q  <= 1'b1;
      end else if (rd_data) begin
        ibf_q <= 1'b0;
      end
      if (done_q && ibf_q && !rd_data)
        ovr_q <= 1'b1;
      else if (rd_stat)
        ovr_q <= 1'b0;
    end
  end

  always_comb begin
    sio_dout = '0;
    if (rd_data)
      sio_dout = ibuf_q;
    else if (rd_stat)
      sio_dout = {14'd0, ovr_q, ibf_q};
  end

  assign ibf     = ibf_q;
  assign ovr     = ovr_q;
  assign ext_irq = irq_q;

endmodule

// File: tb/tb_jtdsp16_sirx.sv
// Directed + randomized bench for jtdsp16_sirx; expected ibuf/ibf/ovr come
// from a word-level model updated whenever the bench completes a frame or reads.
module tb_jtdsp16_sirx;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst, ick, ild, di, byte_mode, sio_rd, siord_full;
  logic [1:0]  cpu_addr;
  logic [15:0] sio_dout;
  logic        ibf, ovr, ext_irq;

  int checks = 0;
  int fails  = 0;
  int lat, irq_at, irq_nx;

  logic [15:0] m_ibuf;
  logic        m_ibf, m_ovr;
  logic [15:0] d;

  jtdsp16_sirx #(.SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .ick        (ick),
    .ild        (ild),
    .di         (di),
    .byte_mode  (byte_mode),
    .sio_rd     (sio_rd),
    .cpu_addr   (cpu_addr),
    .sio_dout   (sio_dout),
    .ibf        (ibf),
    .ovr        (ovr),
    .siord_full (siord_full),
    .ext_irq    (ext_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One serial clock period; records clk edges from ick rise to ibf rising
  task automatic pulse(input logic l, input logic b);
    logic p;
    tick(1);
    ild = l;
    di  = b;
    tick(2);
    p = ibf; lat = -1; irq_at = -1; irq_nx = -1;
    ick = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && !p && ibf) begin
        lat = k; irq_at = int'(ext_irq);
      end else if (lat > 0 && irq_nx < 0) begin
        irq_nx = int'(ext_irq);
      end
    end
    #1 ick = 1'b0;
    ild = 1'b0;
    tick(3);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) pulse(1'b0, w[i]);
  endtask

  task automatic frame(input logic [15:0] w, input int n);
    pulse(1'b1, 1'b0);
    send_bits(w, n);
  endtask

  task automatic model_complete(input logic [15:0] w);
    if (m_ibf) m_ovr = 1'b1;
    m_ibf  = 1'b1;
    m_ibuf = w;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] v);
    sio_rd = 1'b1;
    cpu_addr = a;
    #1 v = sio_dout;
    @(posedge clk);
    #2 sio_rd = 1'b0;
    cpu_addr = 2'd0;
  endtask

  task automatic rd_data(input string tag);
    logic [15:0] v;
    rd(2'd0, v);
    chk(tag, v, m_ibuf);
    m_ibf = 1'b0;
    chk({tag, "_ibf"}, 16'(ibf), 16'(m_ibf));
  endtask

  task automatic rd_stat(input string tag);
    logic [15:0] v;
    rd(2'd1, v);
    chk(tag, v, {14'd0, m_ovr, m_ibf});
    m_ovr = 1'b0;
    chk({tag, "_ovr"}, 16'(ovr), 16'(m_ovr));
    chk({tag, "_ibf"}, 16'(ibf), 16'(m_ibf));
  endtask

  initial begin
    rst = 1'b1; ick = 1'b0; ild = 1'b0; di = 1'b0; byte_mode = 1'b0;
    sio_rd = 1'b0; cpu_addr = 2'd1; siord_full = 1'b0;
    m_ibuf = '0; m_ibf = 1'b0; m_ovr = 1'b0;

    // Reset state
    tick(3);
    chk("rst_ibf", 16'(ibf), 16'd0);
    chk("rst_ovr", 16'(ovr), 16'd0);
    chk("rst_irq", 16'(ext_irq), 16'd0);
    chk("rst_dout_nord", sio_dout, 16'd0);
    rst = 1'b0;
    cpu_addr = 2'd0;
    tick(1);
    chk("post_rst_ibf", 16'(ibf), 16'd0);

    // Basic frame with latency and interrupt timing
    siord_full = 1'b1;
    pulse(1'b1, 1'b0);
    send_bits(16'hA5C3 >> 1, 15);
    pulse(1'b0, 1'b1);
    chk("latency", 16'(lat), 16'(SS + 2));
    chk("irq_with_ibf", 16'(irq_at), 16'd0);
    chk("irq_next", 16'(irq_nx), 16'd1);
    model_complete(16'hA5C3);
    chk("a5c3_ibf", 16'(ibf), 16'(m_ibf));
    rd_data("a5c3_read");

    // Overrun
    frame(16'h1234, 16); model_complete(16'h1234);
    frame(16'hBEEF, 16); model_complete(16'hBEEF);
    chk("ovr_set", 16'(ovr), 16'(m_ovr));
    rd(2'd2, d); chk("addr2_zero", d, 16'd0);
    rd(2'd3, d); chk("addr3_zero", d, 16'd0);
    rd_stat("stat_0003");
    rd_data("beef_read");

    // Byte mode
    byte_mode = 1'b1;
    frame(16'h005A, 8);
`ifdef JTDSP16_SIRX_BYTE_EN
    model_complete(16'h005A);
    chk("byte_ibf", 16'(ibf), 16'(m_ibf));
`else
    chk("byte_wait_ibf", 16'(ibf), 16'd0);
    send_bits(16'h003C, 8);
    model_complete(16'h5A3C);
`endif
    rd_data("byte_read");
    byte_mode = 1'b0;

    // Restart after five bits
    pulse(1'b1, 1'b0);
    send_bits(16'h001F, 5);
    chk("restart_partial_ibf", 16'(ibf), 16'd0);
    frame(16'h8001, 16); model_complete(16'h8001);
    chk("restart_ovr", 16'(ovr), 16'd0);
    rd_data("restart_read");

    // Word completes in the same clk as a data read
    frame(16'h1111, 16); model_complete(16'h1111);
    pulse(1'b1, 1'b0);
    send_bits(16'h2222 >> 1, 15);
    tick(1);
    di = 1'b0;
    tick(2);
    ick = 1'b1;
    repeat (SS + 1) @(posedge clk);
    #2 sio_rd = 1'b1;
    cpu_addr = 2'd0;
    #1 d = sio_dout;
    @(posedge clk);
    #1 sio_rd = 1'b0;
    chk("collide_dout", d, m_ibuf);
    m_ibuf = 16'h2222; m_ibf = 1'b1;
    chk("collide_ibf", 16'(ibf), 16'(m_ibf));
    chk("collide_ovr", 16'(ovr), 16'(m_ovr));
    tick(3);
    ick = 1'b0;
    tick(3);
    chk("collide_irq", 16'(ext_irq), 16'd1);
    rd_data("collide_new");

    // Randomized frames against the model
    for (int it = 0; it < 8; it++) begin
      logic [15:0] w;
      int r;
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        pulse(1'b1, 1'b0);
        send_bits(16'($urandom), $urandom_range(1, 14));
      end
      frame(w, 16);
      model_complete(w);
      r = $urandom_range(0, 2);
      if (r == 0) rd_data("rand_data");
      else if (r == 1) rd_stat("rand_stat");
    end
    rd_stat("rand_stat_end");
    rd_data("rand_data_end");

    // Reset mid-frame
    frame(16'h0F0F, 16); model_complete(16'h0F0F);
    frame(16'hF0F0, 16); model_complete(16'hF0F0);
    chk("pre_rst_ovr", 16'(ovr), 16'(m_ovr));
    pulse(1'b1, 1'b0);
    send_bits(16'h00AB, 7);
    rst = 1'b1;
    tick(2);
    chk("midrst_ibf", 16'(ibf), 16'd0);
    chk("midrst_ovr", 16'(ovr), 16'd0);
    chk("midrst_irq", 16'(ext_irq), 16'd0);
    rst = 1'b0;
    m_ibuf = '0; m_ibf = 1'b0; m_ovr = 1'b0;
    tick(1);
    send_bits(16'hFFFF, 16);
    chk("noild_ibf", 16'(ibf), 16'd0);
    rd_stat("midrst_stat");
    rd_data("midrst_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
